// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at acceptance and committed to HI/LO when the busy window closes.
module mult_div_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        hilo_sel,
  output logic        busy,
  output logic [31:0] mdo
);

  // Handshake: an instruction is taken on a rising edge with start=1, busy=0,
  // cancel=0; anything else leaves all state untouched.

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   hi, lo;
  logic [31:0]   res_hi, res_lo;
  logic          res_valid;
  logic          accept, is_md, done;

  logic [63:0]   prod_s, prod_u;
  logic [31:0]   abs_a, abs_b, den_s, den_u;
  logic [31:0]   uq, ur, sq, sr, dq, dr;

  assign accept = start && !busy && !cancel;
  assign is_md  = !op[2];

  // Signed division runs on magnitudes; a zero divisor is swapped for 1 only
  // to keep the arithmetic defined, the result is discarded anyway.
  always_comb begin
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};
    abs_a  = a[31] ? (32'd0 - a) : a;
    abs_b  = b[31] ? (32'd0 - b) : b;
    den_s  = (b == 32'd0) ? 32'd1 : abs_b;
    den_u  = (b == 32'd0) ? 32'd1 : b;
    uq     = abs_a / den_s;
    ur     = abs_a % den_s;
    sq     = (a[31] ^ b[31]) ? (32'd0 - uq) : uq;
    sr     = a[31] ? (32'd0 - ur) : ur;
    dq     = a / den_u;
    dr     = a % den_u;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept && is_md) state_nxt = S_BUSY;
      S_BUSY: if (cnt == CW'(1))   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_BUSY);
    done = (state == S_BUSY) && (cnt == CW'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      res_valid <= 1'b0;
    end else if (accept) begin
      case (op)
        OP_MULT: begin
          {res_hi, res_lo} <= prod_s;
          res_valid        <= 1'b1;
          cnt              <= CW'(MUL_CYCLES);
        end
        OP_MULTU: begin
          {res_hi, res_lo} <= prod_u;
          res_valid        <= 1'b1;
          cnt              <= CW'(MUL_CYCLES);
        end
        OP_DIV: begin
          res_hi    <= sr;
          res_lo    <= sq;
          res_valid <= (b != 32'd0);
          cnt       <= CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          res_hi    <= dr;
          res_lo    <= dq;
          res_valid <= (b != 32'd0);
          cnt       <= CW'(DIV_CYCLES);
        end
        OP_MTHI: hi <= a;
        OP_MTLO: lo <= a;
        default: ;
      endcase
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (done) begin
        res_valid <= 1'b0;
        if (res_valid) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end

  assign mdo = hilo_sel ? hi : lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed table, corner sequences,
// and random operations against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;

  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic        clk, reset, start, cancel, hilo_sel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] mdo;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] m_hi, m_lo;
  logic [31:0] exp_q[$];

  mult_div_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hilo_sel(hilo_sel), .busy(busy), .mdo(mdo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, pre_hi, pre_lo, exp_hi, exp_lo;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
    hilo_sel = 1'b1; #1; h = mdo;
    hilo_sel = 1'b0; #1; l = mdo;
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    logic [31:0] h, l;
    read_hilo(h, l);
    check({name, ".hi"}, h, eh);
    check({name, ".lo"}, l, el);
  endtask

  // Drives one start cycle; returns at the negedge following the sampling edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic c);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; cancel = c;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    issue(3'd4, h, 32'd0, 1'b0);
    issue(3'd5, l, 32'd0, 1'b0);
    m_hi = h; m_lo = l;
  endtask

  // Reference model: HI/LO update from the architectural definitions.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, q, r;
    longint unsigned pu;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin q = sx * sy; m_hi = q[63:32]; m_lo = q[31:0]; end
      3'd1: begin pu = {32'd0, x} * {32'd0, y}; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      3'd2: if (y != 0) begin q = sx / sy; r = sx % sy; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd3: if (y != 0) begin m_lo = x / y; m_hi = x % y; end
      3'd4: m_hi = x;
      3'd5: m_lo = x;
      default: ;
    endcase
  endtask

  function automatic int model_cycles(input logic [2:0] o);
    if (o <= 3'd1) return MUL_N;
    if (o <= 3'd3) return DIV_N;
    return 0;
  endfunction

  vec_t vt[11];

  initial begin
    int n;
    logic [31:0] h, l;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic        rc;

    vt[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFA, MUL_N};
    vt[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,  32'h0,  32'hFFFFFFFE, 32'h00000001, MUL_N};
    vt[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'h0,  32'h0,  32'hFFFFFFFF, 32'hFFFFFFFD, DIV_N};
    vt[3]  = '{3'd3, 32'd7,        32'd0,        32'h11, 32'h22, 32'h11,       32'h22,       DIV_N};
    vt[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h1,  32'h2,  32'h0,        32'h80000000, DIV_N};
    vt[5]  = '{3'd3, 32'd7,        32'd2,        32'h0,  32'h0,  32'h1,        32'h3,        DIV_N};
    vt[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h0,  32'h0,  32'h1,        32'hFFFFFFFD, DIV_N};
    vt[7]  = '{3'd2, 32'd0,        32'd0,        32'h5,  32'h6,  32'h5,        32'h6,        DIV_N};
    vt[8]  = '{3'd4, 32'h12345678, 32'd0,        32'h0,  32'h0,  32'h12345678, 32'h0,        0};
    vt[9]  = '{3'd6, 32'hDEAD,     32'hBEEF,     32'h33, 32'h44, 32'h33,       32'h44,       0};
    vt[10] = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,  32'h0,  32'h3FFFFFFF, 32'h00000001, MUL_N};

    reset = 1'b1; start = 1'b0; cancel = 1'b0; hilo_sel = 1'b0; op = '0; a = '0; b = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset.busy", {31'd0, busy}, 32'd0);
    check_hilo("reset", 32'd0, 32'd0);

    // Directed table
    foreach (vt[i]) begin
      preload(vt[i].pre_hi, vt[i].pre_lo);
      check($sformatf("v%0d.pre_busy", i), {31'd0, busy}, 32'd0);
      issue(vt[i].op, vt[i].a, vt[i].b, 1'b0);
      if (vt[i].cyc > 0) check_hilo($sformatf("v%0d.old", i), vt[i].pre_hi, vt[i].pre_lo);
      wait_idle(n);
      check($sformatf("v%0d.cycles", i), n, vt[i].cyc);
      check_hilo($sformatf("v%0d", i), vt[i].exp_hi, vt[i].exp_lo);
    end

    // start+cancel on MTLO and on MULT: nothing accepted
    preload(32'h55, 32'h66);
    issue(3'd5, 32'hAA, 32'd0, 1'b1);
    check_hilo("cancel_mtlo", 32'h55, 32'h66);
    issue(3'd0, 32'd9, 32'd9, 1'b1);
    check("cancel_mult.busy", {31'd0, busy}, 32'd0);
    repeat (MUL_N + 1) @(negedge clk);
    check_hilo("cancel_mult", 32'h55, 32'h66);

    // Async reset in the middle of a DIV
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("rst_mid.busy", {31'd0, busy}, 32'd0);
    check_hilo("rst_mid", 32'd0, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (DIV_N + 2) @(negedge clk);
    check_hilo("rst_mid.late", 32'd0, 32'd0);

    // start while busy is ignored; cancel during busy does not abort
    issue(3'd0, 32'd2, 32'd3, 1'b0);
    issue(3'd3, 32'd100, 32'd7, 1'b0);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    wait_idle(n);
    check_hilo("ignored_start", 32'd0, 32'd6);

    // Back-to-back: MULT accepted on the edge right after DIV completes
    issue(3'd3, 32'd9, 32'd2, 1'b0);
    wait_idle(n);
    check("b2b.div_cycles", n, DIV_N);
    check_hilo("b2b.div", 32'd1, 32'd4);
    start = 1'b1; op = 3'd0; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("b2b.busy_rise", {31'd0, busy}, 32'd1);
    wait_idle(n);
    check("b2b.mul_cycles", n, MUL_N);
    check_hilo("b2b.mul", 32'd0, 32'd42);

    // Random operations against the model
    preload(32'd0, 32'd0);
    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 17));
        2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 5));
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 9) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      rc = ($urandom_range(0, 7) == 0);
      issue(ro, ra, rb, rc);
      if (!rc) model_op(ro, ra, rb);
      exp_q.push_back(m_hi);
      exp_q.push_back(m_lo);
      wait_idle(n);
      check($sformatf("rnd%0d.cycles op%0d", k, ro), n, rc ? 0 : model_cycles(ro));
      read_hilo(h, l);
      check($sformatf("rnd%0d.hi op%0d a=%08h b=%08h", k, ro, ra, rb), h, exp_q.pop_front());
      check($sformatf("rnd%0d.lo op%0d a=%08h b=%08h", k, ro, ra, rb), l, exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multiply/divide unit in the EX stage; the producer of the MUL_DIV word that the EX/MEM register captures as MDO_M.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles into internal HI/LO registers, and handles the MTHI/MTLO writes.
- Drives a busy flag that the hazard unit uses to stall MD-class instructions in D.
- Provides the HI or LO value for MFHI/MFLO on mdo.

Parameters:
- MUL_CYCLES, 5, cycles busy stays high for MULT/MULTU (>=1)
- DIV_CYCLES, 10, cycles busy stays high for DIV/DIVU (>=1)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  EX holds a valid MD-class instruction this cycle
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved (no-op)
- a  input  32  forwarded rs value
- b  input  32  forwarded rt value
- cancel  input  1  exception/interrupt flush of the EX instruction this cycle
- hilo_sel  input  1  1 selects HI on mdo, 0 selects LO
- busy  output  1  registered; high while an operation is in flight
- mdo  output  32  combinational: hilo_sel ? HI : LO

Behaviour:
- Reset (async, active-high): HI=0, LO=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the operation; no HI/LO write occurs.
- An operation is accepted when start=1, busy=0, cancel=0 at a rising edge. Otherwise start is ignored, with no state change.
- start while busy=1 is ignored; the hazard unit guarantees it never occurs.
- Operand handling on acceptance of op 0..3:
  - compute the full result from a and b in that edge and hold it internally;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - set busy=1 from the next cycle.
- busy timing:
  - busy stays 1 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES) after the accepting edge.
  - On the edge where the counter reaches 1, HI/LO are written with the held result and busy falls to 0.
  - Example with N=5: accept at edge t0; busy high from t0 to t5; HI/LO updated at t5.
- Result definitions:
  - MULT: {HI,LO} = signed a × signed b, 64-bit.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of a.
    - Special case a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: LO = unsigned quotient, HI = unsigned remainder.
  - Division by zero (DIV or DIVU): the operation still takes DIV_CYCLES with busy high; HI and LO are left unchanged at completion.
- MTHI/MTLO:
  - Accepted under the same start/busy/cancel conditions.
  - HI=a (or LO=a) written at the accepting edge; busy never asserts.
- Reserved op: no effect.
- cancel=1 with start=1 suppresses acceptance entirely, including MTHI/MTLO.
- cancel while busy=1 has no effect. An operation already in flight always completes, so a restarted handler sees a consistent HI/LO.
- mdo:
  - Reflects the HI/LO registers only; it shows old values while busy.
  - The hazard unit stalls MFHI/MFLO while busy or start.
  - A value written by MTHI/MTLO is visible on mdo in the following cycle.
- Back-to-back: start may be accepted in the same cycle busy has just fallen to 0 (busy=0 sampled). There is no dead cycle.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3, start 1 cycle -> busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; mdo shows the old LO=0 while busy.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU a=7, b=0 with prior HI=0x11, LO=0x22 -> busy 10 cycles, HI/LO unchanged.
- MTHI a=0x12345678 -> busy stays 0; hilo_sel=1 gives mdo=0x12345678 next cycle. start+cancel with MTLO a=0xAA -> LO unchanged.
- Reset asserted asynchronously at cycle 3 of a DIV -> busy=0, HI=LO=0 immediately, with no later write. start during busy -> ignored; HI/LO equal the first operation's result only.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0. A MULT accepted on the cycle after a DIV completes -> no idle cycle, busy continuous-low-then-high.
